// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared FIFO geometry used by both the read-side and write-side pointer controllers.
package fifo_rd_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF   = 2;
  localparam int unsigned DEPTH_DEF    = 1 << ADDR_W_DEF;
  localparam int unsigned AE_LEVEL_DEF = 1;

endpackage : fifo_rd_ctrl_pkg

// File: rtl/rd_ptr_counter.sv
// Wrap-extended pointer incrementer; mirror of the write-side counter.
// The carry out of the address bits toggles the wrap bit.
module rd_ptr_counter
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W:0]   ptr
);

  logic [ADDR_W:0] ptr_q;
  logic [ADDR_W:0] ptr_d;
  logic [ADDR_W:0] addr_inc;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ptr_d    = ptr_q;
    addr_inc = {1'b0, ptr_q[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};
    if (en) begin
      ptr_d = {ptr_q[ADDR_W] ^ addr_inc[ADDR_W], addr_inc[ADDR_W-1:0]};
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule : rd_ptr_counter

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller: pop acceptance, read pointer, occupancy,
// empty/almost-empty flags, one-cycle read-valid strobe and sticky underflow.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W:0]   wr_ptr,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              underflow
);

  localparam logic [ADDR_W:0] AE_CMP = AE_LEVEL[ADDR_W:0];

  logic pop;
  logic rd_valid_q, rd_valid_d;
  logic underflow_q, underflow_d;

  rd_ptr_counter #(
    .ADDR_W (ADDR_W)
  ) u_rd_ptr_counter (
    .clock (clock),
    .clear (clear),
    .en    (pop),
    .ptr   (rd_ptr)
  );

  // Full is wrap bits differing with equal address bits, which the modular
  // difference naturally reports as 2**ADDR_W.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    empty        = (wr_ptr == rd_ptr);
    almost_empty = (count <= AE_CMP);
    pop          = rd_en & ~empty;
    rd_valid_d   = pop;
    underflow_d  = underflow_q | (rd_en & empty);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_addr   = rd_ptr[ADDR_W-1:0];
  assign rd_valid  = rd_valid_q;
  assign underflow = underflow_q;

endmodule : fifo_rd_ctrl
